lampfpu_rnd_pack_pipe: RTL

- Round-and-pack back end for the bf16 arithmetic units (E_DW=8, F_DW=7, bias 127).
- Consumes the unrounded result bundle from the mul/add/div units: sign, 8-bit exponent, 12-bit extended fraction, isToRound, isOverflow, isUnderflow.
- Produces a packed 16-bit bf16 word and sticky IEEE exception flags.
- 2-stage pipeline with valid/ready handshake on both sides.

---
 rtl/lampfpu_rnd_pack_pipe.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lampfpu_rnd_pack_pipe.sv
// bf16 round-and-pack back end: a decide stage then an apply stage, with valid/ready on both sides.
// Define LAMP_RND_SKID_EN to get a registered ready_o backed by a 1-entry input skid buffer.
module lampfpu_rnd_pack_pipe #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   s_i,
    input  logic [E_DW-1:0]        e_i,
    input  logic [F_DW+4:0]        f_i,
    input  logic                   isToRound_i,
    input  logic                   isOverflow_i,
    input  logic                   isUnderflow_i,
    input  logic [1:0]             rndMode_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [E_DW+F_DW:0]     result_o,
    input  logic                   flagsClear_i,
    output logic [2:0]             flags_o
);
    localparam int SW = E_DW + F_DW;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RDN = 2'b10;
    localparam logic [1:0] RUP = 2'b11;

    // Only the fraction and G/R/S bits matter here; the overflow and hidden bits are dropped.
    typedef struct packed {
        logic            s;
        logic [E_DW-1:0] e;
        logic [F_DW+2:0] f;
        logic            to_round;
        logic            ovf;
        logic            uf;
        logic [1:0]      mode;
    } bundle_t;

    bundle_t    in_bundle;
    bundle_t    src;
    logic       src_valid;
    logic [1:0] unused_f_top;

    assign unused_f_top = f_i[F_DW+4:F_DW+3];
    assign in_bundle    = '{s: s_i, e: e_i, f: f_i[F_DW+2:0], to_round: isToRound_i,
                            ovf: isOverflow_i, uf: isUnderflow_i, mode: rndMode_i};

    logic            s1_valid_reg;
    logic            s1_s_reg;
    logic [E_DW-1:0] s1_e_reg;
    logic [F_DW-1:0] s1_frac_reg;
    logic            s1_inc_reg;
    logic            s1_nx_reg;
    logic [1:0]      s1_mode_reg;
    logic            s1_tr_reg;
    logic            s1_ovf_reg;
    logic            s1_uf_reg;
    logic [2:0]      entry_flags_reg;

    logic adv1;
    logic adv2;

    assign adv2 = ~valid_o | ready_i;
    assign adv1 = ~s1_valid_reg | adv2;

`ifdef LAMP_RND_SKID_EN
    logic    skid_valid_reg;
    bundle_t skid_reg;
    logic    take_in;

    // ready_o is a pure register output: it only drops once the skid slot holds an entry.
    assign ready_o   = ~skid_valid_reg;
    assign take_in   = valid_i & ready_o;
    assign src       = skid_valid_reg ? skid_reg : in_bundle;
    assign src_valid = skid_valid_reg | take_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_reg <= 1'b0;
            skid_reg       <= '0;
        end else if (skid_valid_reg) begin
            skid_valid_reg <= ~adv1;
        end else if (take_in && !adv1) begin
            skid_valid_reg <= 1'b1;
            skid_reg       <= in_bundle;
        end
    end
`else
    assign ready_o   = adv1;
    assign src       = in_bundle;
    assign src_valid = valid_i;
`endif

    // Stage 1: decide the rounding increment and inexactness.
    logic lsb_bit;
    logic guard_bit;
    logic round_sticky;
    logic nx_next;
    logic inc_next;

    always_comb begin
        lsb_bit      = src.f[3];
        guard_bit    = src.f[2];
        round_sticky = src.f[1] | src.f[0];
        nx_next      = guard_bit | round_sticky;
        inc_next     = 1'b0;
        case (src.mode)
            RNE:     inc_next = guard_bit & (lsb_bit | round_sticky);
            RTZ:     inc_next = 1'b0;
            RDN:     inc_next = src.s & nx_next;
            default: inc_next = ~src.s & nx_next;
        endcase
    end

    // Stage 2: apply the increment; a fraction carry ripples into the exponent for free.
    logic [SW-1:0]   sum;
    logic            ovf;
    logic            ovf_to_inf;
    logic [SW:0]     res_next;
    logic [2:0]      fl_next;
    logic [SW-1:0]   mag_inf;
    logic [SW-1:0]   mag_max;

    assign mag_inf = {{E_DW{1'b1}}, {F_DW{1'b0}}};
    assign mag_max = {{(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};

    always_comb begin
        sum        = {s1_e_reg, s1_frac_reg} + SW'(s1_inc_reg);
        ovf        = s1_ovf_reg | (&sum[SW-1:F_DW]);
        ovf_to_inf = 1'b1;
        case (s1_mode_reg)
            RNE:     ovf_to_inf = 1'b1;
            RTZ:     ovf_to_inf = 1'b0;
            RDN:     ovf_to_inf = s1_s_reg;
            default: ovf_to_inf = ~s1_s_reg;
        endcase
        res_next = {s1_s_reg, sum};
        fl_next  = {1'b0, s1_uf_reg & s1_nx_reg, s1_nx_reg};
        if (!s1_tr_reg) begin
            res_next = {s1_s_reg, s1_e_reg, s1_frac_reg};
            fl_next  = 3'b000;
        end else if (ovf) begin
            res_next = {s1_s_reg, ovf_to_inf ? mag_inf : mag_max};
            fl_next  = 3'b101;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_s_reg        <= 1'b0;
            s1_e_reg        <= '0;
            s1_frac_reg     <= '0;
            s1_inc_reg      <= 1'b0;
            s1_nx_reg       <= 1'b0;
            s1_mode_reg     <= 2'b00;
            s1_tr_reg       <= 1'b0;
            s1_ovf_reg      <= 1'b0;
            s1_uf_reg       <= 1'b0;
            valid_o         <= 1'b0;
            result_o        <= '0;
            entry_flags_reg <= 3'b000;
            flags_o         <= 3'b000;
        end else begin
            if (adv1) begin
                s1_valid_reg <= src_valid;
                s1_s_reg     <= src.s;
                s1_e_reg     <= src.e;
                s1_frac_reg  <= src.f[F_DW+2:3];
                s1_inc_reg   <= inc_next;
                s1_nx_reg    <= nx_next;
                s1_mode_reg  <= src.mode;
                s1_tr_reg    <= src.to_round;
                s1_ovf_reg   <= src.ovf;
                s1_uf_reg    <= src.uf;
            end
            if (adv2) begin
                valid_o <= s1_valid_reg;
                if (s1_valid_reg) begin
                    result_o        <= res_next;
                    entry_flags_reg <= fl_next;
                end
            end
            // A clear that coincides with a transfer still keeps that entry's flags.
            if (valid_o && ready_i) begin
                flags_o <= (flagsClear_i ? 3'b000 : flags_o) | entry_flags_reg;
            end else if (flagsClear_i) begin
                flags_o <= 3'b000;
            end
        end
    end
endmodule
